weight_fetch_sequencer: RTL

//  Sequences reads from one per-block conv weight ROM (sync read, 1-cycle latency, read enable)
//  and streams the weight words to the PE array over a valid/ready interface.
//  One job = `passes` sweeps over `length` consecutive words from `base_addr`, for weight reuse

---
 rtl/weight_fetch_sequencer_if.sv | 30 +++
 rtl/weight_fetch_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// weight_fetch_sequencer_if
// Bundles the two buses of the weight fetch sequencer:
//   ROM side   : rom_en / rom_addr out, rom_data back (1-cycle sync read)
//   Stream side: w_data / w_valid / w_last / w_pass_last out, w_ready back
// master = the sequencer; slave = the ROM plus the PE-array consumer.
// ---------------------------------------------------------------------------
interface weight_fetch_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  rom_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_valid;
    logic                  w_ready;
    logic                  w_last;
    logic                  w_pass_last;

    modport master (
        output rom_en, rom_addr, w_data, w_valid, w_last, w_pass_last,
        input  rom_data, w_ready
    );

    modport slave (
        input  rom_en, rom_addr, w_data, w_valid, w_last, w_pass_last,
        output rom_data, w_ready
    );
endinterface

// File: rtl/weight_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// weight_fetch_sequencer
// Reads `passes` sweeps of `length` consecutive words starting at `base_addr`
// from a synchronous weight ROM and streams them to the PE array through a
// 4-entry FIFO. Reads are only issued while FIFO occupancy plus the read in
// flight leaves room, so the FIFO can never overflow under backpressure.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   i_start, i_abort   job request (IDLE only) / synchronous cancel
//   i_base_addr, i_length, i_passes   job parameters, latched on start
//   o_busy, o_done     job active / 1-cycle normal-completion pulse
//   wf (master)        ROM read port and weight output stream
// ---------------------------------------------------------------------------
module weight_fetch_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int PASS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_length,
    input  logic [PASS_WIDTH-1:0] i_passes,
    output logic                  o_busy,
    output logic                  o_done,
    weight_fetch_sequencer_if.master wf
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_base, r_length, r_offset;
    logic [PASS_WIDTH-1:0] r_passes, r_pass;
    logic                  r_done, w_done_next;
    logic                  r_pend_valid, r_pend_last, r_pend_pass_last;
    logic [1:0]            r_wr_ptr, r_rd_ptr;
    logic [2:0]            r_count;

    logic                  w_issue, w_push, w_pop, w_final_pop;
    logic                  w_credit_ok, w_offset_end, w_pass_end, w_zero_job, w_accept;
    logic [DATA_WIDTH-1:0] w_entry_data [4];
    logic [3:0]            w_entry_last, w_entry_pass_last;

    assign w_offset_end = (r_offset == r_length - 1'b1);
    assign w_pass_end   = (r_pass == r_passes - 1'b1);
    assign w_zero_job   = (i_length == '0) || (i_passes == '0);
    assign w_accept     = (r_state == S_IDLE) && i_start && !i_abort;
    // The single pending read is the only data not yet in the FIFO, so the
    // credit check is occupancy plus that read against the FIFO depth.
    assign w_credit_ok  = (r_count + 3'(r_pend_valid)) < 3'd4;
    assign w_push       = r_pend_valid;
    assign w_pop        = wf.w_valid && wf.w_ready;
    assign w_final_pop  = w_pop && w_entry_last[r_rd_ptr] && w_entry_pass_last[r_rd_ptr];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_zero_job) w_done_next  = 1'b1;
                    else            w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_issue = w_credit_ok;
                if (w_issue && w_offset_end && w_pass_end) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_final_pop) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // Abort wins over everything, including a start in the same cycle.
        if (i_abort) begin
            w_state_next = S_IDLE;
            w_issue      = 1'b0;
            w_done_next  = 1'b0;
        end
    end

    // ---------------- job registers and address counters ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base   <= '0;
            r_length <= '0;
            r_passes <= '0;
            r_offset <= '0;
            r_pass   <= '0;
        end else if (w_accept) begin
            r_base   <= i_base_addr;
            r_length <= i_length;
            r_passes <= i_passes;
            r_offset <= '0;
            r_pass   <= '0;
        end else if (w_issue) begin
            if (w_offset_end) begin
                r_offset <= '0;
                r_pass   <= r_pass + 1'b1;
            end else begin
                r_offset <= r_offset + 1'b1;
            end
        end
    end

    // Tags for the read in flight; the ROM word joins them next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_valid     <= 1'b0;
            r_pend_last      <= 1'b0;
            r_pend_pass_last <= 1'b0;
        end else begin
            r_pend_valid     <= w_issue;
            r_pend_last      <= w_offset_end;
            r_pend_pass_last <= w_pass_end;
        end
    end

    // ---------------- 4-entry output FIFO ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] r_data;
            logic                  r_last, r_pass_last;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data      <= '0;
                    r_last      <= 1'b0;
                    r_pass_last <= 1'b0;
                end else if (w_push && (r_wr_ptr == 2'(gi))) begin
                    r_data      <= wf.rom_data;
                    r_last      <= r_pend_last;
                    r_pass_last <= r_pend_pass_last;
                end
            end
            assign w_entry_data[gi]      = r_data;
            assign w_entry_last[gi]      = r_last;
            assign w_entry_pass_last[gi] = r_pass_last;
        end
    endgenerate

    // On abort the pending read's data is dropped because the count and
    // pointers are cleared in the same cycle it would have been pushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = r_done;
    assign wf.rom_en      = w_issue;
    assign wf.rom_addr    = r_base + r_offset;   // wraps modulo 2^ADDR_WIDTH
    assign wf.w_valid     = (r_count != 3'd0);
    assign wf.w_data      = w_entry_data[r_rd_ptr];
    assign wf.w_last      = w_entry_last[r_rd_ptr];
    assign wf.w_pass_last = w_entry_pass_last[r_rd_ptr];
endmodule
